// File: rtl/store_to_fetch_receiver.sv
// store_to_fetch_receiver
// Accepts redirect packets from the store stage over a flag/ack bus and
// buffers them in a 2-entry FIFO. The FIFO head is presented to the fetch core.
// Packet layout: {tid[TID_W-1:0], pc[ADDR_W-1:0]}, tid in the MSBs.
// Optional statistics counters are enabled by defining STF_RX_STATS_EN.
//
// Handshakes:
//   Store side (flag/ack): the sender holds bus_can_receive=1 with stable
//   bus_data until it sees bus_ack. The packet is written on the edge that
//   leaves IDLE. ACK drives bus_ack for one cycle. SETTLE ignores the flag
//   for one more cycle while the sender clears it. Accepts are therefore at
//   least 3 cycles apart, and one packet is never taken twice.
//   Fetch side (valid/ready): an entry pops on every edge where
//   redir_valid=1 and redir_ready=1. redir_ready has no effect while
//   redir_valid=0.
module store_to_fetch_receiver #(
  parameter int ADDR_W = 32,
  parameter int TID_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bus_can_receive,
  input  logic [TID_W+ADDR_W-1:0] bus_data,
  output logic                    bus_ack,
  output logic                    redir_valid,
  output logic [ADDR_W-1:0]       redir_pc,
  output logic [TID_W-1:0]        redir_tid,
  input  logic                    redir_ready,
  output logic [15:0]             rx_count,
  output logic [15:0]             stall_count,
  output logic [1:0]              dbg_state_o
);

  localparam int PKT_W = TID_W + ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACK    = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PKT_W-1:0] mem0_q, mem1_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             fifo_full;
  logic             accept;
  logic             pop;
  logic [PKT_W-1:0] head;

  // Full is taken from the registered count, before any same-edge pop.
  assign fifo_full   = (count_q == 2'd2);
  assign accept      = (state_q == ST_IDLE) && bus_can_receive && !fifo_full;
  assign redir_valid = (count_q != 2'd0);
  assign pop         = redir_valid && redir_ready;
  assign dbg_state_o = state_q;

  // The head is read combinationally; the output is zero while the FIFO is empty.
  assign head      = rd_ptr_q ? mem1_q : mem0_q;
  assign redir_pc  = redir_valid ? head[ADDR_W-1:0] : '0;
  assign redir_tid = redir_valid ? head[PKT_W-1 -: TID_W] : '0;

  // State register for the bus handshake FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and the ack output.
  always_comb begin
    state_d = state_q;
    bus_ack = 1'b0;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACK;
      ST_ACK: begin
        bus_ack = 1'b1;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Occupancy update. A write and a pop on the same edge leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, 1-bit pointers that wrap modulo 2, and the occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (accept) begin
        if (wr_ptr_q) mem1_q <= bus_data;
        else          mem0_q <= bus_data;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

`ifdef STF_RX_STATS_EN
  logic [15:0] rx_count_q, stall_count_q;
  logic        stall;

  // A stall is a cycle in IDLE with a pending packet and a full FIFO.
  assign stall = (state_q == ST_IDLE) && bus_can_receive && fifo_full;

  // Accept and stall counters. Both saturate at 16'hFFFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      if (accept && (rx_count_q != 16'hFFFF))   rx_count_q    <= rx_count_q + 16'd1;
      if (stall && (stall_count_q != 16'hFFFF)) stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign rx_count    = rx_count_q;
  assign stall_count = stall_count_q;
`else
  assign rx_count    = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_store_to_fetch_receiver.sv
// Directed bench for store_to_fetch_receiver (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are checked at that
// same point, so they show the state after the edge.
module tb_store_to_fetch_receiver;

`ifdef STF_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACK    = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  logic        clk;
  logic        reset;
  logic        bus_can_receive;
  logic [35:0] bus_data;
  logic        bus_ack;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [3:0]  redir_tid;
  logic        redir_ready;
  logic [15:0] rx_count;
  logic [15:0] stall_count;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;
  int exp_rx = 0;
  int acks;

  store_to_fetch_receiver #(.ADDR_W(32), .TID_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus_can_receive (bus_can_receive),
    .bus_data        (bus_data),
    .bus_ack         (bus_ack),
    .redir_valid     (redir_valid),
    .redir_pc        (redir_pc),
    .redir_tid       (redir_tid),
    .redir_ready     (redir_ready),
    .rx_count        (rx_count),
    .stall_count     (stall_count),
    .dbg_state_o     (dbg_state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_stat(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  // The sender holds its flag until ack, then clears it. The task then waits
  // through SETTLE so the FSM is back in IDLE.
  task automatic send(input logic [3:0] tid, input logic [31:0] pc, input string tag);
    bus_data        = {tid, pc};
    bus_can_receive = 1'b1;
    tick();
    check({tag, "_ack"}, 64'(bus_ack), 64'd1);
    exp_rx++;
    bus_can_receive = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain(input string tag);
    redir_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!redir_valid) break;
      tick();
    end
    check({tag, "_drained"}, 64'(redir_valid), 64'd0);
    redir_ready = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus_can_receive = 1'b0;
    bus_data        = '0;
    redir_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   64'(bus_ack),     64'd0);
    check("rst_valid", 64'(redir_valid), 64'd0);
    check("rst_pc",    64'(redir_pc),    64'd0);
    check("rst_tid",   64'(redir_tid),   64'd0);
    check("rst_state", 64'(dbg_state_o), 64'(S_IDLE));
    check("rst_rx",    64'(rx_count),    64'd0);
    check("rst_stall", 64'(stall_count), 64'd0);

    // Single packet. The first edge with reset low accepts it.
    reset           = 1'b0;
    bus_data        = {4'd3, 32'h0000_1000};
    bus_can_receive = 1'b1;
    redir_ready     = 1'b1;
    tick();
    exp_rx++;
    check("t1_ack",   64'(bus_ack),     64'd1);
    check("t1_valid", 64'(redir_valid), 64'd1);
    check("t1_pc",    64'(redir_pc),    64'h1000);
    check("t1_tid",   64'(redir_tid),   64'd3);
    check("t1_state", 64'(dbg_state_o), 64'(S_ACK));
    bus_can_receive = 1'b0;
    tick();
    check("t1_ack_gone",  64'(bus_ack),     64'd0);
    check("t1_popped",    64'(redir_valid), 64'd0);
    check("t1_settle",    64'(dbg_state_o), 64'(S_SETTLE));
    tick();
    check("t1_idle",      64'(dbg_state_o), 64'(S_IDLE));
    check("t1_rx",        64'(rx_count),    exp_stat(exp_rx));
    redir_ready = 1'b0;

    // Flag held for 6 cycles with the same data. Expect accepts at t0 and t3.
    bus_data        = {4'd1, 32'h0000_0100};
    bus_can_receive = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_ack) acks++;
    end
    exp_rx += 2;
    check("t2_acks",  64'(acks),        64'd2);
    check("t2_full",  64'(redir_valid), 64'd1);
    check("t2_pc",    64'(redir_pc),    64'h100);
    check("t2_state", 64'(dbg_state_o), 64'(S_IDLE));

    // FIFO full with the flag still pending: five stalled cycles, no ack.
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_ack) acks++;
    end
    check("t3_no_ack", 64'(acks),        64'd0);
    check("t3_stall",  64'(stall_count), exp_stat(5));
    check("t3_rx",     64'(rx_count),    exp_stat(exp_rx));
    // A pop on this edge frees a slot, but full was sampled before the pop.
    redir_ready = 1'b1;
    tick();
    check("t3_pop_no_ack", 64'(bus_ack),     64'd0);
    check("t3_pop_valid",  64'(redir_valid), 64'd1);
    redir_ready = 1'b0;
    tick();
    exp_rx++;
    check("t3_late_ack", 64'(bus_ack),  64'd1);
    check("t3_late_rx",  64'(rx_count), exp_stat(exp_rx));
    bus_can_receive = 1'b0;
    tick();
    tick();
    drain("t3");

    // Order: the entry written first is presented first.
    send(4'd2, 32'h0000_0100, "t4_a");
    send(4'd5, 32'h0000_0200, "t4_b");
    check("t4_pc0",  64'(redir_pc),  64'h100);
    check("t4_tid0", 64'(redir_tid), 64'd2);
    redir_ready = 1'b1;
    tick();
    check("t4_pc1",  64'(redir_pc),  64'h200);
    check("t4_tid1", 64'(redir_tid), 64'd5);
    tick();
    check("t4_empty", 64'(redir_valid), 64'd0);
    redir_ready = 1'b0;

    // A write and a pop on the same edge: occupancy stays at one.
    send(4'd7, 32'h0000_0A00, "t5_a");
    bus_data        = {4'd8, 32'h0000_0B00};
    bus_can_receive = 1'b1;
    redir_ready     = 1'b1;
    tick();
    exp_rx++;
    check("t5_ack",   64'(bus_ack),     64'd1);
    check("t5_valid", 64'(redir_valid), 64'd1);
    check("t5_pc",    64'(redir_pc),    64'hB00);
    check("t5_tid",   64'(redir_tid),   64'd8);
    bus_can_receive = 1'b0;
    tick();
    check("t5_one_entry", 64'(redir_valid), 64'd0);
    redir_ready = 1'b0;
    tick();

    // redir_ready while empty has no effect, including no underflow.
    redir_ready = 1'b1;
    tick();
    tick();
    check("t6_empty", 64'(redir_valid), 64'd0);
    redir_ready = 1'b0;
    send(4'd9, 32'hDEAD_BEE0, "t6");
    check("t6_valid", 64'(redir_valid), 64'd1);
    check("t6_pc",    64'(redir_pc),    64'hDEAD_BEE0);
    check("t6_rx",    64'(rx_count),    exp_stat(exp_rx));
    drain("t6");

    // Reset asserted while bus_ack is high discards the transfer.
    bus_data        = {4'd4, 32'h0000_4400};
    bus_can_receive = 1'b1;
    tick();
    check("t7_ack_pre", 64'(bus_ack), 64'd1);
    reset = 1'b1;
    #1;
    check("t7_ack",   64'(bus_ack),     64'd0);
    check("t7_valid", 64'(redir_valid), 64'd0);
    check("t7_state", 64'(dbg_state_o), 64'(S_IDLE));
    check("t7_pc",    64'(redir_pc),    64'd0);
    check("t7_rx",    64'(rx_count),    64'd0);
    bus_can_receive = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    exp_rx = 0;

    // Ten accepts. rx_count counts them, or stays zero without statistics.
    redir_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(4'(i), 32'h0000_1000 + 32'(i * 4), "t8");
      check("t8_rx", 64'(rx_count), exp_stat(exp_rx));
    end
    check("t8_stall", 64'(stall_count), 64'd0);
    drain("t8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
